serial_pattern_scheduler: RTL and testbench

//  Shares one serial 010/101 pattern-match engine among N_CH requester channels.
//  - Each channel submits a DW-bit word for scanning.
//  - A round-robin arbiter grants one job at a time.
//  - The engine shifts the word MSB-first through a 3-bit window and counts matches.
//  - Returns count and channel id with a one-cycle done pulse.
//  - Sits between the per-channel bit sources and the match-statistics logic.

---
 rtl/serial_pattern_scheduler_if.sv | 25 ++
 rtl/serial_pattern_scheduler.sv | 123 ++++++++++++
 tb/tb_serial_pattern_scheduler.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/serial_pattern_scheduler_if.sv
// Job request/grant/result bundle between requester channels and the shared match engine.
// Optional mask lane is present only when DETECT_MASK_EN is defined.
interface serial_pattern_scheduler_if #(
   parameter int N_CH = 4,
   parameter int DW   = 8
);
   localparam int CW = $clog2(DW-1);

   logic [N_CH-1:0]    req;
   logic [N_CH*DW-1:0] data;
   logic [N_CH-1:0]    grant;
   logic               busy;
   logic               done;
   logic [2:0]         done_id;
   logic [CW-1:0]      done_count;
`ifdef DETECT_MASK_EN
   logic [1:0]         mask;

   modport master (output req, data, mask, input grant, busy, done, done_id, done_count);
   modport slave  (input req, data, mask, output grant, busy, done, done_id, done_count);
`else
   modport master (output req, data, input grant, busy, done, done_id, done_count);
   modport slave  (input req, data, output grant, busy, done, done_id, done_count);
`endif
endinterface

// File: rtl/serial_pattern_scheduler.sv
// Round-robin shared serial 010/101 matcher; DW+3 cycles per job (IDLE, LOAD, DW x SHIFT, DONE).
// Optional DETECT_MASK_EN adds a 2-bit per-job pattern enable mask sampled in LOAD.
module serial_pattern_scheduler #(
   parameter int N_CH = 4,
   parameter int DW   = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   serial_pattern_scheduler_if.slave  bus
);
   localparam int CW = $clog2(DW-1);
   localparam int IW = $clog2(DW);

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

   state_t          state, state_nxt;
   logic [2:0]      winner, rr_ptr, pick;
   logic            pick_ok;
   logic [DW-1:0]   word;
   logic [2:0]      win, win_nxt;
   logic [CW-1:0]   count, count_nxt;
   logic [IW-1:0]   idx;
   logic            last_bit, hit, en_010, en_101;
   logic [2:0]      done_id_q;
   logic [CW-1:0]   done_count_q;
`ifdef DETECT_MASK_EN
   logic [1:0]      mask_q;
   assign en_010 = mask_q[0];
   assign en_101 = mask_q[1];
`else
   assign en_010 = 1'b1;
   assign en_101 = 1'b1;
`endif

   // Search from the rr pointer upward, wrapping past N_CH-1 back to channel 0.
   always_comb begin
      int c;
      c       = 0;
      pick    = rr_ptr;
      pick_ok = 1'b0;
      for (int k = 0; k < N_CH; k++) begin
         c = int'(rr_ptr) + k;
         if (c >= N_CH) c = c - N_CH;
         if (!pick_ok && bus.req[c]) begin
            pick_ok = 1'b1;
            pick    = 3'(c);
         end
      end
   end

   assign last_bit  = (idx == IW'(DW-1));
   assign win_nxt   = {win[1:0], word[IW'(DW-1) - idx]};
   assign hit       = (idx >= IW'(2)) &&
                      ((en_010 && win_nxt == 3'b010) || (en_101 && win_nxt == 3'b101));
   assign count_nxt = count + CW'(hit);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (pick_ok) state_nxt = LOAD;
         LOAD:    state_nxt = SHIFT;
         SHIFT:   if (last_bit) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         winner       <= '0;
         rr_ptr       <= '0;
         word         <= '0;
         win          <= '0;
         count        <= '0;
         idx          <= '0;
         done_id_q    <= '0;
         done_count_q <= '0;
`ifdef DETECT_MASK_EN
         mask_q       <= '0;
`endif
      end else begin
         case (state)
            IDLE: if (pick_ok) winner <= pick;
            LOAD: begin
               word  <= bus.data[int'(winner)*DW +: DW];
               win   <= '0;
               count <= '0;
               idx   <= '0;
`ifdef DETECT_MASK_EN
               mask_q <= bus.mask;
`endif
            end
            SHIFT: begin
               win   <= win_nxt;
               count <= count_nxt;
               idx   <= idx + IW'(1);
               // Result registers update on the edge into DONE so they are valid with the pulse.
               if (last_bit) begin
                  done_id_q    <= winner;
                  done_count_q <= count_nxt;
               end
            end
            DONE: rr_ptr <= (winner == 3'(N_CH-1)) ? 3'd0 : winner + 3'd1;
            default: ;
         endcase
      end
   end

   always_comb begin
      bus.grant = '0;
      for (int i = 0; i < N_CH; i++)
         bus.grant[i] = (state == LOAD) && (winner == 3'(i));
      bus.busy       = (state != IDLE);
      bus.done       = (state == DONE);
      bus.done_id    = done_id_q;
      bus.done_count = done_count_q;
   end
endmodule

// File: tb/tb_serial_pattern_scheduler.sv
// Self-checking bench: directed and random jobs against a sliding-window / round-robin reference.
module tb_serial_pattern_scheduler;
   localparam int N_CH = 4;
   localparam int DW   = 8;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   passed = 0;
   int   total = 0;
   int   rr_m = 0;
   int   last_grant_cyc, last_done_cyc;
   logic [1:0] cur_mask = 2'b11;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   serial_pattern_scheduler_if #(.N_CH(N_CH), .DW(DW)) bus();
   serial_pattern_scheduler #(.N_CH(N_CH), .DW(DW)) dut (.clk(clk), .reset(reset), .bus(bus));

   task automatic step();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   function automatic logic [N_CH-1:0] onehot(input int ch);
      logic [N_CH-1:0] v;
      v = '0;
      v[ch] = 1'b1;
      return v;
   endfunction

   // Count every 3-bit window of the word (MSB-first) that reads as an enabled pattern.
   function automatic int ref_count(input logic [DW-1:0] w, input logic [1:0] m);
      int n;
      logic [2:0] t;
      n = 0;
      for (int p = DW-1; p >= 2; p--) begin
         t = {w[p], w[p-1], w[p-2]};
         if ((t == 3'b010 && m[0]) || (t == 3'b101 && m[1])) n++;
      end
      return n;
   endfunction

   function automatic int rr_pick(input logic [N_CH-1:0] r, input int start);
      for (int k = 0; k < N_CH; k++)
         if (r[(start + k) % N_CH]) return (start + k) % N_CH;
      return -1;
   endfunction

   task automatic set_data(input int ch, input logic [DW-1:0] w);
      bus.data[ch*DW +: DW] = w;
   endtask

   // Wait for the grant of exp_ch, then follow its job to the done pulse.
   task automatic serve(input int exp_ch, input bit drop, input int raise_ch, input string tag);
      int waited;
      logic [DW-1:0] w;
      waited = 0;
      while (bus.grant == '0 && waited < 40) begin
         step();
         waited++;
      end
      chk({tag, "_grant"}, 32'(bus.grant), 32'(onehot(exp_ch)));
      chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
      last_grant_cyc = cyc;
      w = bus.data[exp_ch*DW +: DW];
      if (drop) bus.req[exp_ch] = 1'b0;
      if (raise_ch >= 0) bus.req[raise_ch] = 1'b1;
      repeat (DW) step();
      chk({tag, "_nodone"}, 32'(bus.done), 32'd0);
      step();
      last_done_cyc = cyc;
      chk({tag, "_done"}, 32'(bus.done), 32'd1);
      chk({tag, "_id"}, 32'(bus.done_id), 32'(exp_ch));
      chk({tag, "_count"}, 32'(bus.done_count), 32'(ref_count(w, cur_mask)));
      rr_m = (exp_ch + 1) % N_CH;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      rr_m = 0;
      step();
   endtask

   initial begin
      int t_req, g_prev, w, saw_done;
      logic [N_CH-1:0] r;
      bus.req  = '0;
      bus.data = '0;
`ifdef DETECT_MASK_EN
      bus.mask = 2'b11;
`endif
      do_reset();
      chk("rst_grant", 32'(bus.grant), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_id", 32'(bus.done_id), 32'd0);
      chk("rst_count", 32'(bus.done_count), 32'd0);

      // Single job on ch0: latency and the alternating-bit count.
      set_data(0, 8'b01010101);
      bus.req = 4'b0001;
      t_req = cyc;
      serve(0, 1'b1, -1, "t2");
      chk("t2_grant_lat", 32'(last_grant_cyc), 32'(t_req + 1));
      chk("t2_done_lat", 32'(last_done_cyc), 32'(t_req + DW + 2));
      chk("t2_count6", 32'(bus.done_count), 32'd6);
      step();
      chk("t2_pulse", 32'(bus.done), 32'd0);
      chk("t2_held_id", 32'(bus.done_id), 32'd0);

      // ch1 and ch2 together; pointer now at 1.
      set_data(2, 8'b11101000);
      set_data(1, 8'h00);
      bus.req = 4'b0110;
      serve(1, 1'b1, -1, "t3a");
      serve(2, 1'b1, -1, "t3b");
      chk("t3_count2", 32'(bus.done_count), 32'd2);

      // Reset in the middle of a shift phase aborts the job.
      set_data(1, 8'h5A);
      bus.req = 4'b0010;
      w = 0;
      while (bus.grant == '0 && w < 40) begin step(); w++; end
      bus.req = '0;
      repeat (4) step();
      reset = 1'b1;
      step();
      chk("t1_grant", 32'(bus.grant), 32'd0);
      chk("t1_busy", 32'(bus.busy), 32'd0);
      chk("t1_done", 32'(bus.done), 32'd0);
      chk("t1_id", 32'(bus.done_id), 32'd0);
      chk("t1_count", 32'(bus.done_count), 32'd0);
      reset = 1'b0;
      rr_m = 0;
      saw_done = 0;
      repeat (DW + 5) begin
         step();
         if (bus.done) saw_done++;
      end
      chk("t1_no_done", 32'(saw_done), 32'd0);

      // All channels held: rotate 0,1,2,3,0 back to back.
      for (int i = 0; i < N_CH; i++) set_data(i, DW'($urandom));
      bus.req = '1;
      g_prev = -1;
      for (int j = 0; j < 5; j++) begin
         serve(rr_pick(bus.req, rr_m), 1'b0, -1, "t4");
         chk("t4_order", 32'(bus.done_id), 32'(j % N_CH));
         if (g_prev >= 0) chk("t4_spacing", 32'(last_grant_cyc - g_prev), 32'(DW + 3));
         g_prev = last_grant_cyc;
      end
      bus.req = '0;
      repeat (3) step();

      // ch3 rises mid-job on ch0 and is served right after the following IDLE.
      do_reset();
      set_data(0, DW'($urandom));
      set_data(3, DW'($urandom));
      bus.req = 4'b0001;
      serve(0, 1'b1, 3, "t5a");
      t_req = last_done_cyc;
      serve(3, 1'b1, -1, "t5b");
      chk("t5_gap", 32'(last_grant_cyc), 32'(t_req + 2));

      // Random request sets, served in model round-robin order.
      for (int round = 0; round < 6; round++) begin
         for (int i = 0; i < N_CH; i++) set_data(i, DW'($urandom));
         r = N_CH'($urandom_range(1, (1 << N_CH) - 1));
         bus.req = r;
         while (bus.req != '0) serve(rr_pick(bus.req, rr_m), 1'b1, -1, "rnd");
      end

`ifdef DETECT_MASK_EN
      for (int m = 0; m < 4; m++) begin
         cur_mask = (m == 0) ? 2'b01 : (m == 1) ? 2'b10 : (m == 2) ? 2'b00 : 2'b11;
         bus.mask = cur_mask;
         set_data(1, 8'b01010101);
         bus.req = 4'b0010;
         serve(1, 1'b1, -1, "t6");
         chk("t6_const", 32'(bus.done_count),
             (m == 2) ? 32'd0 : (m == 3) ? 32'd6 : 32'd3);
      end
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
